branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Parametrised branch prediction and resolution unit for the RV32 core. It holds a direct-mapped table of 2-bit saturating counters indexed by PC and gives a taken/not-taken prediction to fetch in the same cycle. At execute it evaluates the RISC-V branch condition from funct3 and the comparator flags, flags a mispredict, and trains the table on the next clock edge.

## Interface
- ENTRIES, 64: number of table entries; power of two, 4..1024.
- PC_W, 32: PC width.
- IDX_W, $clog2(ENTRIES): derived; not overridable.
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- if_pc  input  PC_W  fetch-stage PC to predict.
- pred_taken  output  1  prediction for if_pc.
- init_busy  output  1  table initialisation in progress.
- ex_valid  input  1  execute-stage instruction valid.
- Branch  input  1  the instruction is a conditional branch.
- ex_pc  input  PC_W  PC of the resolving branch.
- funct3  input  3  branch funct3.
- eq, lt, ltu  input  1 each  comparator flags: equal, signed less-than, unsigned less-than.
- ex_pred_taken  input  1  prediction carried down the pipe with the branch.
- take_branch  output  1  resolved branch outcome.
- mispredict  output  1  resolved outcome differs from ex_pred_taken.
- stat_branches  output  32  resolved-branch count (BP_STATS_EN only).
- stat_mispred  output  32  mispredict count (BP_STATS_EN only).

## Operation
- Index is pc[IDX_W+1:2]. No tags, so aliasing is accepted.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. The prediction is the counter MSB.
- State machine:
  - INIT: a sweep counter writes 01 to entry 0..ENTRIES-1, one entry per cycle.
  - RUN: entered after the last INIT write. The unit stays in RUN until rst.
- A resolve is active when ex_valid && Branch && funct3 is legal.
- Condition evaluation:
  - 000 BEQ: eq.
  - 001 BNE: !eq.
  - 100 BLT: lt.
  - 101 BGE: !lt.
  - 110 BLTU: ltu.
  - 111 BGEU: !ltu.
  - 010 and 011 are illegal: take_branch=0, mispredict=0, no update, no stat increment.
- take_branch = resolve active && condition.
- mispredict = resolve active && (take_branch != ex_pred_taken).
- Update, in RUN with resolve active: entry[ex_pc index] increments if taken and decrements if not. It saturates at 11 and 00.
- In INIT: pred_taken=0, and all updates are dropped. take_branch and mispredict are still computed.

## Timing
- pred_taken, take_branch and mispredict are combinational; there is zero-cycle latency to the outputs.
- A table update takes effect at the next rising clk edge. A lookup of the same index in the same cycle returns the old value; there is no bypass.
- rst high at an edge: state goes to INIT, the sweep counter to 0, and the stat counters to 0.
- After rst, init_busy=1 and pred_taken=0.
- init_busy falls in the cycle after the entry ENTRIES-1 write. The unit is therefore busy for exactly ENTRIES cycles after the rst cycle.
- rst asserted mid-INIT or in RUN restarts the sweep at entry 0.

## Configuration
- BP_STATS_EN defined:
  - stat_branches increments on each active resolve in RUN.
  - stat_mispred increments on each mispredict in RUN.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and clear on rst.
- BP_STATS_EN undefined: both ports are present and tied to 0, and no counter logic is generated.

## Structure
- bp_pkg holds:
  - the funct3 constants BEQ, BNE, BLT, BGE, BLTU, BGEU;
  - the counter encoding constants and the INIT counter value (01);
  - the state enum for INIT and RUN.
- Sub-module branch_cond_eval is combinational. It takes funct3, eq, lt and ltu, and produces cond and legal.
- The table is a flop array written through one port, which keeps it RAM-inferable.

## Test plan
(ENTRIES=16 throughout.)
- Reset: hold rst 1 cycle.
  - init_busy=1 for exactly 16 cycles, then 0.
  - pred_taken=0 throughout.
  - After init, if_pc=0x40 gives pred_taken=0 (counter 01).
- Training: 2 taken BEQ resolves (eq=1) at ex_pc=0x40.
  - The counter goes 01, 10, 11.
  - if_pc=0x40 gives pred_taken=1.
  - A third taken resolve leaves it at 11 (saturation).
- Conditions: feed funct3 = 101, lt=0 → take_branch=1.
  - 110, ltu=0 → take_branch=0.
  - 011 → take_branch=0, mispredict=0, counter unchanged.
- Mispredict: ex_pred_taken=1, BNE, eq=1 → take_branch=0, mispredict=1, and the counter decrements.
- Aliasing and same-cycle hazard: resolve at 0x40 while if_pc=0x80 (same index).
  - In that cycle pred_taken shows the old value.
  - In the next cycle it shows the updated value.
- Stats (BP_STATS_EN): 5 resolves, 2 of them mispredicted → stat_branches=5, stat_mispred=2.
  - A mid-INIT rst after 7 sweep cycles restarts the sweep, and init_busy stays high for another 16 cycles.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared constants and types for the branch prediction unit.
package bp_pkg;

  // RV32 conditional-branch funct3 encodings
  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  // 2-bit saturating counter encoding; the MSB is the prediction
  localparam logic [1:0] CTR_SNT  = 2'b00;
  localparam logic [1:0] CTR_WNT  = 2'b01;
  localparam logic [1:0] CTR_WT   = 2'b10;
  localparam logic [1:0] CTR_ST   = 2'b11;
  localparam logic [1:0] CTR_INIT = CTR_WNT;

  typedef enum logic {ST_INIT, ST_RUN} bp_state_t;

  // Saturating step of a counter toward the resolved outcome
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST)  ? CTR_ST  : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational RISC-V branch condition evaluation from funct3 and comparator flags.
module branch_cond_eval
  import bp_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       eq,
  input  logic       lt,
  input  logic       ltu,
  output logic       cond,
  output logic       legal
);

  // Decode funct3; 010/011 are not branches and report illegal with cond low
  always_comb begin
    cond  = 1'b0;
    legal = 1'b1;
    case (funct3)
      BEQ:     cond = eq;
      BNE:     cond = !eq;
      BLT:     cond = lt;
      BGE:     cond = !lt;
      BLTU:    cond = ltu;
      BGEU:    cond = !ltu;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped 2-bit counter branch predictor with execute-stage resolution.
// Optional macro BP_STATS_EN enables resolved-branch / mispredict counters.
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int PC_W    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic            init_busy,
  input  logic            ex_valid,
  input  logic            Branch,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [2:0]      funct3,
  input  logic            eq,
  input  logic            lt,
  input  logic            ltu,
  input  logic            ex_pred_taken,
  output logic            take_branch,
  output logic            mispredict,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);

  bp_state_t        state, next_state;
  logic [IDX_W-1:0] sweep;
  logic [1:0]       bp_table [ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic             cond, legal, active, run;
  logic             we;
  logic [IDX_W-1:0] waddr;
  logic [1:0]       wdata;

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  // Tag-free indexing leaves the upper and byte-offset PC bits unused
  logic unused_pc;
  assign unused_pc = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                       ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

  branch_cond_eval u_cond (
    .funct3 (funct3),
    .eq     (eq),
    .lt     (lt),
    .ltu    (ltu),
    .cond   (cond),
    .legal  (legal)
  );

  assign run         = (state == ST_RUN);
  assign active      = ex_valid && Branch && legal;
  assign take_branch = active && cond;
  assign mispredict  = active && (take_branch != ex_pred_taken);
  assign pred_taken  = run && bp_table[if_idx][1];

  // State register and init sweep counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      sweep <= '0;
    end else begin
      state <= next_state;
      if (state == ST_INIT) sweep <= sweep + 1'b1;
    end
  end

  // Next-state: leave INIT once the last entry has been written
  always_comb begin
    next_state = state;
    init_busy  = (state == ST_INIT);
    if (state == ST_INIT && sweep == IDX_W'(ENTRIES-1)) next_state = ST_RUN;
  end

  // Single write port: init sweep owns it in INIT, training owns it in RUN
  always_comb begin
    we    = 1'b0;
    waddr = ex_idx;
    wdata = ctr_next(bp_table[ex_idx], take_branch);
    if (!rst) begin
      if (state == ST_INIT) begin
        we    = 1'b1;
        waddr = sweep;
        wdata = CTR_INIT;
      end else if (active) begin
        we = 1'b1;
      end
    end
  end

  // Counter table; no reset so it can map onto a RAM
  always_ff @(posedge clk) begin
    if (we) bp_table[waddr] <= wdata;
  end

`ifdef BP_STATS_EN
  // Saturating resolve / mispredict counters, counted only in RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (run) begin
      if (active && !(&stat_branches))    stat_branches <= stat_branches + 32'd1;
      if (mispredict && !(&stat_mispred)) stat_mispred  <= stat_mispred + 32'd1;
    end
  end
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed testbench for branch_predict_unit with ENTRIES=16.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken, init_busy;
  logic        ex_valid, Branch;
  logic [31:0] ex_pc;
  logic [2:0]  funct3;
  logic        eq, lt, ltu, ex_pred_taken;
  logic        take_branch, mispredict;
  logic [31:0] stat_branches, stat_mispred;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(.ENTRIES(16), .PC_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_pc         (if_pc),
    .pred_taken    (pred_taken),
    .init_busy     (init_busy),
    .ex_valid      (ex_valid),
    .Branch        (Branch),
    .ex_pc         (ex_pc),
    .funct3        (funct3),
    .eq            (eq),
    .lt            (lt),
    .ltu           (ltu),
    .ex_pred_taken (ex_pred_taken),
    .take_branch   (take_branch),
    .mispredict    (mispredict),
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic e, input logic l, input logic lu,
                       input logic [31:0] pc, input logic pt);
    ex_valid = 1'b1; Branch = 1'b1; funct3 = f3;
    eq = e; lt = l; ltu = lu; ex_pc = pc; ex_pred_taken = pt;
    #1;
  endtask

  task automatic idle;
    ex_valid = 1'b0; Branch = 1'b0; funct3 = 3'b000;
    eq = 1'b0; lt = 1'b0; ltu = 1'b0; ex_pred_taken = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    idle();
    if_pc = 32'h40;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      vectors++;
      if (init_busy !== 1'b1) begin
        errors++; $display("FAIL reset_busy cyc%0d: got %b want 1", i, init_busy);
      end
      vectors++;
      if (pred_taken !== 1'b0) begin
        errors++; $display("FAIL reset_pred cyc%0d: got %b want 0", i, pred_taken);
      end
      tick();
    end
    #1;
    vectors++;
    if (init_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy_end: got %b want 0", init_busy);
    end
    vectors++;
    if (pred_taken !== 1'b0) begin
      errors++; $display("FAIL reset_pred_0x40: got %b want 0", pred_taken);
    end
  endtask

  task automatic test_training;
    if_pc = 32'h40;
    // 01 -> 10
    drive(3'b000, 1'b1, 1'b0, 1'b0, 32'h40, 1'b0);
    vectors++;
    if (take_branch !== 1'b1 || mispredict !== 1'b1) begin
      errors++; $display("FAIL train1_out: got tb=%b mp=%b want tb=1 mp=1", take_branch, mispredict);
    end
    tick();
    vectors++;
    if (pred_taken !== 1'b1) begin
      errors++; $display("FAIL train1_pred: got %b want 1", pred_taken);
    end
    // 10 -> 11
    drive(3'b000, 1'b1, 1'b0, 1'b0, 32'h40, 1'b1);
    vectors++;
    if (take_branch !== 1'b1 || mispredict !== 1'b0) begin
      errors++; $display("FAIL train2_out: got tb=%b mp=%b want tb=1 mp=0", take_branch, mispredict);
    end
    tick();
    vectors++;
    if (pred_taken !== 1'b1) begin
      errors++; $display("FAIL train2_pred: got %b want 1", pred_taken);
    end
    // 11 stays 11
    drive(3'b000, 1'b1, 1'b0, 1'b0, 32'h40, 1'b1);
    tick();
    idle();
    vectors++;
    if (pred_taken !== 1'b1) begin
      errors++; $display("FAIL train3_pred: got %b want 1", pred_taken);
    end
  endtask

  task automatic test_mispredict;
    // BNE with eq=1 is not taken; 11 -> 10 proves saturation held at 11
    drive(3'b001, 1'b1, 1'b0, 1'b0, 32'h40, 1'b1);
    vectors++;
    if (take_branch !== 1'b0 || mispredict !== 1'b1) begin
      errors++; $display("FAIL mispred_out: got tb=%b mp=%b want tb=0 mp=1", take_branch, mispredict);
    end
    tick();
    idle();
    vectors++;
    if (pred_taken !== 1'b1) begin
      errors++; $display("FAIL mispred_dec_pred: got %b want 1", pred_taken);
    end
  endtask

  task automatic test_conditions;
    drive(3'b101, 1'b0, 1'b0, 1'b0, 32'h44, 1'b0);
    vectors++;
    if (take_branch !== 1'b1) begin
      errors++; $display("FAIL cond_bge: got %b want 1", take_branch);
    end
    tick();
    drive(3'b110, 1'b0, 1'b0, 1'b0, 32'h44, 1'b0);
    vectors++;
    if (take_branch !== 1'b0) begin
      errors++; $display("FAIL cond_bltu: got %b want 0", take_branch);
    end
    tick();
    drive(3'b100, 1'b0, 1'b1, 1'b0, 32'h44, 1'b0);
    vectors++;
    if (take_branch !== 1'b1) begin
      errors++; $display("FAIL cond_blt: got %b want 1", take_branch);
    end
    drive(3'b111, 1'b0, 1'b0, 1'b1, 32'h44, 1'b0);
    vectors++;
    if (take_branch !== 1'b0) begin
      errors++; $display("FAIL cond_bgeu: got %b want 0", take_branch);
    end
    drive(3'b001, 1'b0, 1'b0, 1'b0, 32'h44, 1'b0);
    vectors++;
    if (take_branch !== 1'b1) begin
      errors++; $display("FAIL cond_bne: got %b want 1", take_branch);
    end
    // non-branch instruction never resolves
    drive(3'b000, 1'b1, 1'b0, 1'b0, 32'h44, 1'b1);
    Branch = 1'b0;
    #1;
    vectors++;
    if (take_branch !== 1'b0 || mispredict !== 1'b0) begin
      errors++; $display("FAIL cond_nobranch: got tb=%b mp=%b want 0 0", take_branch, mispredict);
    end
    // illegal funct3 at 0x40 (counter 10): no outcome, no update
    drive(3'b011, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1);
    vectors++;
    if (take_branch !== 1'b0 || mispredict !== 1'b0) begin
      errors++; $display("FAIL cond_f3_011: got tb=%b mp=%b want 0 0", take_branch, mispredict);
    end
    tick();
    drive(3'b010, 1'b0, 1'b0, 1'b0, 32'h40, 1'b1);
    vectors++;
    if (take_branch !== 1'b0 || mispredict !== 1'b0) begin
      errors++; $display("FAIL cond_f3_010: got tb=%b mp=%b want 0 0", take_branch, mispredict);
    end
    tick();
    idle();
    if_pc = 32'h40;
    #1;
    vectors++;
    if (pred_taken !== 1'b1) begin
      errors++; $display("FAIL cond_illegal_noupd: got %b want 1", pred_taken);
    end
    // BGEU with ltu=1: not taken, correctly predicted; 10 -> 01
    drive(3'b111, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    vectors++;
    if (take_branch !== 1'b0 || mispredict !== 1'b0) begin
      errors++; $display("FAIL cond_bgeu_nt: got tb=%b mp=%b want 0 0", take_branch, mispredict);
    end
    tick();
    idle();
    vectors++;
    if (pred_taken !== 1'b0) begin
      errors++; $display("FAIL cond_dec_pred: got %b want 0", pred_taken);
    end
  endtask

  task automatic test_alias;
    // 0x40 and 0x80 share index 0 (counter 01)
    if_pc = 32'h80;
    drive(3'b000, 1'b1, 1'b0, 1'b0, 32'h40, 1'b0);
    vectors++;
    if (pred_taken !== 1'b0) begin
      errors++; $display("FAIL alias_same_cycle: got %b want 0", pred_taken);
    end
    tick();
    idle();
    vectors++;
    if (pred_taken !== 1'b1) begin
      errors++; $display("FAIL alias_next_cycle: got %b want 1", pred_taken);
    end
  endtask

  task automatic test_stats;
    if_pc = 32'h48;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    // a mispredicted taken resolve held through INIT must be dropped
    drive(3'b000, 1'b1, 1'b0, 1'b0, 32'h48, 1'b0);
    vectors++;
    if (take_branch !== 1'b1 || mispredict !== 1'b1) begin
      errors++; $display("FAIL stats_init_out: got tb=%b mp=%b want 1 1", take_branch, mispredict);
    end
    for (int i = 0; i < 16; i++) tick();
    idle();
    vectors++;
    if (init_busy !== 1'b0 || pred_taken !== 1'b0) begin
      errors++; $display("FAIL stats_init_drop: got busy=%b pred=%b want 0 0", init_busy, pred_taken);
    end
    vectors++;
    if (stat_branches !== 32'd0 || stat_mispred !== 32'd0) begin
      errors++; $display("FAIL stats_init_zero: got %0d/%0d want 0/0", stat_branches, stat_mispred);
    end
    drive(3'b000, 1'b1, 1'b0, 1'b0, 32'h48, 1'b1); tick();  // ok
    drive(3'b000, 1'b1, 1'b0, 1'b0, 32'h48, 1'b0); tick();  // mispredict
    drive(3'b001, 1'b1, 1'b0, 1'b0, 32'h48, 1'b0); tick();  // ok
    drive(3'b100, 1'b0, 1'b1, 1'b0, 32'h48, 1'b0); tick();  // mispredict
    drive(3'b101, 1'b0, 1'b1, 1'b0, 32'h48, 1'b0); tick();  // ok
    drive(3'b010, 1'b1, 1'b1, 1'b1, 32'h48, 1'b1); tick();  // illegal, ignored
    drive(3'b000, 1'b1, 1'b0, 1'b0, 32'h48, 1'b0);
    Branch = 1'b0;
    tick();                                                 // not a branch
    idle();
`ifdef BP_STATS_EN
    vectors++;
    if (stat_branches !== 32'd5) begin
      errors++; $display("FAIL stats_branches: got %0d want 5", stat_branches);
    end
    vectors++;
    if (stat_mispred !== 32'd2) begin
      errors++; $display("FAIL stats_mispred: got %0d want 2", stat_mispred);
    end
`else
    vectors++;
    if (stat_branches !== 32'd0 || stat_mispred !== 32'd0) begin
      errors++; $display("FAIL stats_tied: got %0d/%0d want 0/0", stat_branches, stat_mispred);
    end
`endif
  endtask

  task automatic test_mid_init_reset;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      vectors++;
      if (init_busy !== 1'b1) begin
        errors++; $display("FAIL midinit_busy cyc%0d: got %b want 1", i, init_busy);
      end
      tick();
    end
    #1;
    vectors++;
    if (init_busy !== 1'b0) begin
      errors++; $display("FAIL midinit_busy_end: got %b want 0", init_busy);
    end
`ifdef BP_STATS_EN
    vectors++;
    if (stat_branches !== 32'd0 || stat_mispred !== 32'd0) begin
      errors++; $display("FAIL midinit_stats_clr: got %0d/%0d want 0/0", stat_branches, stat_mispred);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    if_pc = '0;
    ex_pc = '0;
    ex_valid = 1'b0; Branch = 1'b0; funct3 = '0;
    eq = 1'b0; lt = 1'b0; ltu = 1'b0; ex_pred_taken = 1'b0;
    test_reset();
    test_training();
    test_mispredict();
    test_conditions();
    test_alias();
    test_stats();
    test_mid_init_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
